// File: rtl/rv_pkg.sv
// Shared fetch-path types and constants: entry layout, FSM states and the
// instruction field positions used by the decode-side outputs.
package rv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  function automatic logic [4:0] inst_rd(input logic [31:0] inst);
    return inst[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
    return inst[RS1_MSB:RS1_LSB];
  endfunction

  function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
    return inst[RS2_MSB:RS2_LSB];
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the instruction-memory, redirect and decode-handshake signals
// around the fetch sequencer; master is the sequencer side.
interface fetch_ctrl_if;

  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic        out_fault;

  modport master (
    output imem_pc,
    input  imem_inst,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_rd,
    output out_rs1,
    output out_rs2,
    output out_fault
  );

  modport slave (
    input  imem_pc,
    output imem_inst,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_rd,
    input  out_rs1,
    input  out_rs2,
    input  out_fault
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush wins over push/pop and the
// head reads as all-zero whenever the queue is empty.
module fetch_queue
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_nxt;
  logic          pop_eff;
  logic          push_eff;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign head  = empty ? '0 : mem[rd_ptr];

  // Pushing into a full queue is only legal when the head leaves this cycle.
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);

  always_comb begin
    count_nxt = count_q;
    case ({push_eff, pop_eff})
      2'b10:   count_nxt = count_q + (AW+1)'(1);
      2'b01:   count_nxt = count_q - (AW+1)'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_eff) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_nxt;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, checks fetch addresses,
// feeds the entry queue and handles redirects and address faults.
//
// state | meaning
// FETCH | fetching one word per cycle whenever the queue can take it
// HALT  | a fault entry was queued; no fetches until redirect or reset
module fetch_ctrl
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          IMEM_BYTES  = 3200
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  localparam int          CW         = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [31:0] LAST_FETCH = 32'(IMEM_BYTES - 4);

  fetch_state_t  state_q;
  fetch_state_t  state_nxt;
  logic [31:0]   pc_q;
  logic [31:0]   pc_nxt;
  logic          pop;
  logic          push;
  logic          push_ok;
  logic          flush;
  logic          addr_ok;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign pop     = bus.out_valid & bus.out_ready;
  assign push_ok = ~full | pop;
  assign addr_ok = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_FETCH);

  always_comb begin
    state_nxt  = state_q;
    pc_nxt     = pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    push_entry = '0;
    if (bus.redirect_valid) begin
      flush     = 1'b1;
      pc_nxt    = bus.redirect_pc;
      state_nxt = FETCH;
    end else if (state_q == FETCH && push_ok) begin
      push = 1'b1;
      if (addr_ok) begin
        push_entry = '{pc: pc_q, inst: bus.imem_inst, fault: 1'b0};
        pc_nxt     = pc_q + 32'd4;
      end else begin
        // Fault entry carries a NOP so downstream field decode stays benign.
        push_entry = '{pc: pc_q, inst: NOP_INST, fault: 1'b1};
        state_nxt  = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
    end
  end

  assign bus.imem_pc   = pc_q;
  assign bus.out_valid = ~empty;
  assign bus.out_inst  = head.inst;
  assign bus.out_pc    = head.pc;
  assign bus.out_fault = head.fault;
  assign bus.out_rd    = inst_rd(head.inst);
  assign bus.out_rs1   = inst_rs1(head.inst);
  assign bus.out_rs2   = inst_rs2(head.inst);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference model of the fetch rules.
module tb_fetch_ctrl;
  import rv_pkg::*;

  localparam int          DEPTH  = 2;
  localparam int          IMEM   = 3200;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (DEPTH),
    .IMEM_BYTES  (IMEM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [IMEM/4];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a < 32'(IMEM)) return mem[int'(a >> 2)];
    return 32'hDEAD_BEEF;
  endfunction

  always_comb bus.imem_inst = mem_rd(bus.imem_pc);

  int checks = 0;
  int errors = 0;

  exp_t        q[$];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          known = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Check the current cycle, then apply inputs for it and advance the model.
  task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
    exp_t e;
    bit   pop;
    bit   push_ok;
    @(negedge clk);
    if (known) begin
      if (q.size() != 0) e = q[0];
      else e = '{pc: 32'h0, inst: 32'h0, fault: 1'b0};
      chk("imem_pc",   bus.imem_pc, m_pc);
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
      chk("out_pc",    bus.out_pc, e.pc);
      chk("out_inst",  bus.out_inst, e.inst);
      chk("out_fault", {31'b0, bus.out_fault}, {31'b0, e.fault});
      chk("out_rd",    {27'b0, bus.out_rd},  {27'b0, e.inst[11:7]});
      chk("out_rs1",   {27'b0, bus.out_rs1}, {27'b0, e.inst[19:15]});
      chk("out_rs2",   {27'b0, bus.out_rs2}, {27'b0, e.inst[24:20]});
    end
    rst                = r;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;

    pop     = (q.size() != 0) && rdy;
    push_ok = (q.size() < DEPTH) || pop;
    if (r) begin
      q.delete();
      m_pc   = RST_PC;
      m_halt = 0;
      known  = 1;
    end else if (known) begin
      if (rv) begin
        q.delete();
        m_pc   = rpc;
        m_halt = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (!m_halt && push_ok) begin
          if (m_pc % 4 == 0 && m_pc + 4 <= 32'(IMEM)) begin
            q.push_back('{pc: m_pc, inst: mem_rd(m_pc), fault: 1'b0});
            m_pc = m_pc + 4;
          end else begin
            q.push_back('{pc: m_pc, inst: 32'h0000_0013, fault: 1'b1});
            m_halt = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_target();
    int sel = int'($urandom_range(0, 9));
    if (sel < 7) return 32'($urandom_range(0, IMEM/4 - 1)) << 2;
    if (sel == 7) return (32'($urandom_range(0, IMEM/4 - 1)) << 2) | 32'($urandom_range(1, 3));
    return 32'(IMEM - 16) + (32'($urandom_range(0, 6)) << 2);
  endfunction

  initial begin
    rst                = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    for (int i = 0; i < IMEM/4; i++) mem[i] = $urandom;
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h0020_8133;

    // reset release and streaming
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);

    // backpressure then release
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);

    // redirect to 0x40 while queue holds pc 8,12
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'h40);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // misaligned redirect faults and halts; redirect resumes
    step(0, 1, 1, 32'h42);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h10);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // run off the end of memory
    step(0, 1, 1, 32'(IMEM - 20));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);

    // reset with full queue and simultaneous redirect
    step(0, 1, 1, 32'h100);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 1, 32'h200);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 24) == 0), rand_target());
    end
    step(0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
